demux_stream_router: RTL and testbench

- Parametrised registered 1-to-NUM_OUT demultiplexer; generalises the team's 1-to-4 combinational demux.
- Routes a valid/ready input stream of DATA_W-bit words to one of NUM_OUT output channels.
- Each output channel has a one-entry holding register with its own valid/ready handshake.
- Two routing modes: directed (per-word select) and auto-sweep (internal round-robin pointer). Sits between a single producer and several downstream consumers.

---
 rtl/demux_stream_router.sv | 152 +++++++++++++++
 tb/tb_demux_stream_router.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_router.sv
// ---------------------------------------------------------------------------
// demux_stream_router
//   Registered 1-to-NUM_OUT stream demultiplexer. A single valid/ready input
//   stream is steered into one of NUM_OUT one-entry output holding registers.
//   Each output register has its own valid/ready handshake.
//
//   Routing modes
//     mode = 0 : directed. Each word goes to channel in_sel.
//     mode = 1 : auto-sweep. Words go to channel cur_ptr. The pointer
//                advances only on an accepted word and wraps at NUM_OUT-1.
//
//   Ports
//     clk, rst_n           clock (rising edge), async active-low reset
//     in_valid/in_ready    input handshake (in_ready does not look at in_valid)
//     in_data, in_sel      input word and directed-mode destination
//     mode                 0 = directed, 1 = auto-sweep
//     out_valid[k]         channel k holds a word
//     out_ready[k]         consumer k takes the word
//     out_data             channel k at bits [k*DATA_W +: DATA_W]
//     cur_ptr              auto-sweep pointer
//     sel_err, err_cnt     only with DEMUX_SEL_ERR_EN. sel_err is a sticky flag
//                          for an out-of-range select. err_cnt counts discarded
//                          words and saturates at 255.
//
//   Optional build macro: DEMUX_SEL_ERR_EN
//   Legal configuration: 2 <= NUM_OUT <= 16, 2**SEL_W >= NUM_OUT.
// ---------------------------------------------------------------------------

// Per-channel one-entry holding register.
// A write has priority over a drain. Writing a channel while its consumer
// takes the old word therefore replaces that word with no bubble.
// Data is only loaded on a write, so it stays put after the word drains.
module demux_chan #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              vld,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (wr_en) begin
            vld  <= 1'b1;
            data <= wr_data;
        end else if (vld && rd_ready) begin
            vld  <= 1'b0;
        end
    end
endmodule

module demux_stream_router #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      mode,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]          cur_ptr
`ifdef DEMUX_SEL_ERR_EN
    ,
    output logic                      sel_err,
    output logic [7:0]                err_cnt
`endif
);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_OUT - 1);

    logic [SEL_W-1:0]                ptr_q;
    logic [SEL_W-1:0]                tgt;
    logic [NUM_OUT-1:0]              tgt_oh;
    logic [NUM_OUT-1:0]              wr_en;
    logic [NUM_OUT-1:0][DATA_W-1:0]  chan_data;
    logic                            xfer;

    // The target channel is combinational, so a mode change takes effect in
    // the same cycle.
    assign tgt = mode ? ptr_q : in_sel;

    // Build a one-hot decode of the target. A select >= NUM_OUT decodes to
    // all zeros. That makes in_ready 1 and drops the word with no write.
    genvar k;
    generate
        for (k = 0; k < NUM_OUT; k++) begin : g_dec
            assign tgt_oh[k] = (tgt == SEL_W'(k));
        end
    endgenerate

    // The target can accept when it is empty or when it drains this cycle.
    assign in_ready = ~|(tgt_oh & out_valid & ~out_ready);
    assign xfer     = in_valid & in_ready;
    assign wr_en    = tgt_oh & {NUM_OUT{xfer}};

    generate
        for (k = 0; k < NUM_OUT; k++) begin : g_chan
            demux_chan #(.DATA_W(DATA_W)) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (wr_en[k]),
                .wr_data  (in_data),
                .rd_ready (out_ready[k]),
                .vld      (out_valid[k]),
                .data     (chan_data[k])
            );
        end
    endgenerate

    assign out_data = chan_data;

    // The sweep pointer moves only on an accepted auto-sweep word. A stalled
    // channel therefore holds the pointer rather than being skipped. The
    // wrap is explicit so that NUM_OUT does not have to be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (xfer && mode) begin
            ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + SEL_W'(1);
        end
    end

    assign cur_ptr = ptr_q;

`ifdef DEMUX_SEL_ERR_EN
    // An out-of-range word is always accepted, because in_ready is 1 when no
    // channel is hit. So in_valid alone marks a discard.
    logic oor;
    assign oor = in_valid & ~mode & ~|tgt_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else if (oor) begin
            sel_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream_router.sv
// ---------------------------------------------------------------------------
// tb_demux_stream_router
//   Scoreboard bench for a 3-channel router. Three channels exercise both the
//   non-power-of-two wrap and an out-of-range select (3).
//
//   Timeline inside each clock period (posedge = P):
//     P+1  stimulus drives the inputs
//     P+3  stimulus checks in_ready, cur_ptr and the error outputs
//     P+4  monitor checks every channel and pops the words being drained
//     P+6  stimulus pushes the accepted word into that channel's queue
//
//   Reference model: one FIFO of expected words per channel. Channel k is
//   occupied exactly when its FIFO is non-empty. The bench also keeps the
//   last word written to each channel, plus a sweep index taken modulo N.
// ---------------------------------------------------------------------------
module tb_demux_stream_router;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sel;
    logic            mode;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic [SW-1:0]   cur_ptr;
`ifdef DEMUX_SEL_ERR_EN
    logic            sel_err;
    logic [7:0]      err_cnt;
`endif

    demux_stream_router #(.DATA_W(DW), .NUM_OUT(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cur_ptr   (cur_ptr)
`ifdef DEMUX_SEL_ERR_EN
        ,
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] exp_q [N][$];
    logic [DW-1:0] last  [N];
    int            mptr;
    int            merr;
    int            mcnt;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            last[k] = '0;
        end
        mptr = 0;
        merr = 0;
        mcnt = 0;
    endfunction

    // One clock of stimulus: drive the inputs, predict in_ready, and record
    // the transfer if the word is taken.
    task automatic cycle(input logic v, input logic [SW-1:0] sel, input logic m,
                         input logic [DW-1:0] d, input logic [N-1:0] ordy);
        int  tgt;
        bit  rdy;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = sel;
        mode      = m;
        in_data   = d;
        out_ready = ordy;
        #2;
        tgt = m ? mptr : int'(sel);
        rdy = (tgt >= N) ? 1'b1 : (exp_q[tgt].size() == 0 || ordy[tgt]);
        check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        check("cur_ptr", {30'd0, cur_ptr}, mptr);
`ifdef DEMUX_SEL_ERR_EN
        check("sel_err", {31'd0, sel_err}, merr);
        check("err_cnt", {24'd0, err_cnt}, mcnt);
`endif
        #3;
        if (v && rdy) begin
            if (tgt < N) begin
                exp_q[tgt].push_back(d);
                last[tgt] = d;
            end else begin
                merr = 1;
                if (mcnt < 255) mcnt++;
            end
            if (m) mptr = (mptr + 1) % N;
        end
    endtask

    // Assert reset between clock edges. The effect is checked before the
    // next edge, so this also proves the reset is asynchronous.
    task automatic async_reset();
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", {29'd0, out_valid}, 0);
        check("rst_cur_ptr", {30'd0, cur_ptr}, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: compare each channel against its expected FIFO, and retire
    // the words whose consumer handshake completes at the coming edge.
    initial begin
        forever begin
            @(posedge clk);
            #4;
            for (int k = 0; k < N; k++) begin
                check($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
                      {31'd0, exp_q[k].size() != 0});
                check($sformatf("out_data[%0d]", k), {24'd0, out_data[k*DW +: DW]},
                      {24'd0, last[k]});
                if (exp_q[k].size() != 0) begin
                    check($sformatf("head_data[%0d]", k), {24'd0, out_data[k*DW +: DW]},
                          {24'd0, exp_q[k][0]});
                    if (out_ready[k]) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        logic m_r;
        int   rdy_pct;
        logic [N-1:0] ordy;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
        mode = 1'b0; out_ready = '0;
        model_reset();
        #2;
        check("reset_in_ready", {31'd0, in_ready}, 1);
        check("reset_out_valid", {29'd0, out_valid}, 0);
        check("reset_cur_ptr", {30'd0, cur_ptr}, 0);
        check("reset_out_data", out_data, 0);
        #10 rst_n = 1'b1;

        // Directed basic: the second word to channel 2 stalls until drained
        cycle(1, 2, 0, 8'hA1, 3'b000);
        cycle(1, 2, 0, 8'hA2, 3'b000);
        cycle(1, 2, 0, 8'hA2, 3'b000);
        cycle(1, 2, 0, 8'hA2, 3'b100);
        cycle(0, 0, 0, 8'h00, 3'b111);

        // Back-to-back into a draining channel
        cycle(1, 1, 0, 8'h10, 3'b010);
        cycle(1, 1, 0, 8'h11, 3'b010);
        cycle(1, 1, 0, 8'h12, 3'b010);
        cycle(0, 1, 0, 8'h00, 3'b010);

        // Auto-sweep wrap on 3 channels: lands 0,1,2,0,1 and the pointer ends at 2
        for (int i = 1; i <= 5; i++) cycle(1, 0, 1, 8'(i), 3'b111);
        cycle(0, 0, 1, 8'h00, 3'b111);
        check("wrap_ptr", {30'd0, cur_ptr}, 2);

        // Sweep stall: fill ch1, walk the pointer onto it, stall, then release
        cycle(1, 1, 0, 8'h55, 3'b000);
        cycle(1, 0, 1, 8'h66, 3'b000);
        cycle(1, 0, 1, 8'h67, 3'b000);
        cycle(1, 0, 1, 8'h68, 3'b000);
        cycle(1, 0, 1, 8'h68, 3'b000);
        check("stall_ptr", {30'd0, cur_ptr}, 1);
        cycle(1, 0, 1, 8'h68, 3'b010);
        cycle(0, 0, 1, 8'h00, 3'b000);
        check("unstall_ptr", {30'd0, cur_ptr}, 2);
        cycle(0, 0, 0, 8'h00, 3'b111);

        // Reset mid-operation with channels 0 and 2 full and the pointer at 2
        cycle(1, 0, 0, 8'h31, 3'b000);
        cycle(1, 2, 0, 8'h32, 3'b000);
        cycle(0, 0, 0, 8'h00, 3'b000);
        async_reset();

        // Out-of-range select: accepted and dropped. err_cnt saturates when enabled.
        for (int i = 0; i < 300; i++) cycle(1, 3, 0, 8'(i), 3'(i));
        cycle(0, 0, 0, 8'h00, 3'b000);

        // Randomised traffic in blocks with different back-pressure levels
        m_r = 1'b0;
        for (int b = 0; b < 8; b++) begin
            rdy_pct = 10 + b * 12;
            if (b == 4) async_reset();
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) m_r = ~m_r;
                for (int k = 0; k < N; k++) ordy[k] = ($urandom_range(0, 99) < rdy_pct);
                cycle(($urandom_range(0, 3) != 0), SW'($urandom_range(0, 3)), m_r,
                      DW'($urandom), ordy);
            end
        end
        cycle(0, 0, 0, 8'h00, 3'b111);
        cycle(0, 0, 0, 8'h00, 3'b111);

        @(posedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
